ln_forward_scheduler: RTL and testbench

- Controller that shares one layer-norm forward unit among N_REQ tile requesters (e.g. attention-head output buffers).
- Arbitrates round-robin and drives the unit's input_ready/output_taken handshake.
- Steers the datapath mux via a one-hot grant, returns a per-requester response handshake, and flags a hung unit with a timeout.

---
 rtl/ln_forward_scheduler_if.sv | 33 +++
 rtl/ln_forward_scheduler.sv | 146 ++++++++++++++
 tb/tb_ln_forward_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ln_forward_scheduler_if.sv
// Signal bundle between the LN forward scheduler, its requesters and the shared LN unit.
// The master side is the scheduler; the slave side is the requesters plus the unit.
interface ln_forward_scheduler_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic [N_REQ-1:0] resp_valid;
  logic [N_REQ-1:0] resp_ready;
  logic             ln_input_ready;
  logic             ln_output_taken;
  logic             ln_done;
  logic [1:0]       ln_state;
  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] op_count;

  modport master (
    input  req, resp_ready, ln_done, ln_state,
    output gnt, gnt_idx, resp_valid, ln_input_ready, ln_output_taken, busy, timeout_err,
           op_count
  );

  modport slave (
    output req, resp_ready, ln_done, ln_state,
    input  gnt, gnt_idx, resp_valid, ln_input_ready, ln_output_taken, busy, timeout_err,
           op_count
  );
endinterface

// File: rtl/ln_forward_scheduler.sv
// Round-robin scheduler sharing one layer-norm forward unit among N_REQ requesters.
// All outputs are registered from the next-state decode, so they change one cycle after the cause.
module ln_forward_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  ln_forward_scheduler_if.master bus
);
  localparam int unsigned IDX_W  = $clog2(N_REQ);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT);

  localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IdxLast  = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0]  OneHot0  = N_REQ'(1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDeliver,
    StRelease,
    StErr
  } state_e;

  state_e            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_sel, w_sel_nxt;
  logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic [CNT_W-1:0]  r_op_count, w_op_count_nxt;

  logic [IDX_W-1:0]  w_cand, w_pick;
  logic              w_found;

  logic              w_grant_on;
  logic [N_REQ-1:0]  w_gnt, w_resp_valid;

  logic [N_REQ-1:0]  r_gnt, r_resp_valid;
  logic [IDX_W-1:0]  r_gnt_idx;
  logic              r_input_ready, r_output_taken, r_busy, r_timeout_err;

  // First requesting index at or after r_ptr, wrapping modulo N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_cand = IDX_W'((32'(r_ptr) + i) % N_REQ);
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_ptr_nxt      = r_ptr;
    w_wait_cnt_nxt = r_wait_cnt;
    w_op_count_nxt = r_op_count;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_sel_nxt   = w_pick;
          w_state_nxt = StIssue;
        end
      end
      StIssue: begin
        if (bus.ln_state == 2'b00) begin
          w_state_nxt    = StWait;
          w_wait_cnt_nxt = '0;
        end
      end
      StWait: begin
        w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        // Completion wins over a timeout landing in the same cycle.
        if (bus.ln_done) begin
          w_state_nxt = StDeliver;
        end else if (r_wait_cnt == WaitLast) begin
          w_state_nxt = StErr;
        end
      end
      StDeliver: begin
        if (bus.resp_ready[r_sel]) begin
          w_state_nxt = StRelease;
        end
      end
      StRelease: begin
        if (bus.ln_state == 2'b10) begin
          w_op_count_nxt = r_op_count + CNT_W'(1);
          w_ptr_nxt      = (r_sel == IdxLast) ? '0 : r_sel + IDX_W'(1);
          w_state_nxt    = StIdle;
        end
      end
      StErr:   w_state_nxt = StErr;
      default: w_state_nxt = StIdle;
    endcase
  end

  // The unit reads its input through the grant mux, so the grant spans ISSUE through RELEASE.
  assign w_grant_on   = (w_state_nxt inside {StIssue, StWait, StDeliver, StRelease});
  assign w_gnt        = w_grant_on ? (OneHot0 << w_sel_nxt) : '0;
  assign w_resp_valid = (w_state_nxt == StDeliver) ? (OneHot0 << w_sel_nxt) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StIdle;
      r_sel          <= '0;
      r_ptr          <= '0;
      r_wait_cnt     <= '0;
      r_op_count     <= '0;
      r_gnt          <= '0;
      r_gnt_idx      <= '0;
      r_resp_valid   <= '0;
      r_input_ready  <= 1'b0;
      r_output_taken <= 1'b0;
      r_busy         <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_sel          <= w_sel_nxt;
      r_ptr          <= w_ptr_nxt;
      r_wait_cnt     <= w_wait_cnt_nxt;
      r_op_count     <= w_op_count_nxt;
      r_gnt          <= w_gnt;
      r_gnt_idx      <= w_grant_on ? w_sel_nxt : '0;
      r_resp_valid   <= w_resp_valid;
      r_input_ready  <= (w_state_nxt == StIssue);
      r_output_taken <= (w_state_nxt == StRelease);
      r_busy         <= (w_state_nxt != StIdle);
      r_timeout_err  <= (w_state_nxt == StErr);
    end
  end

  assign bus.gnt             = r_gnt;
  assign bus.gnt_idx         = r_gnt_idx;
  assign bus.resp_valid      = r_resp_valid;
  assign bus.ln_input_ready  = r_input_ready;
  assign bus.ln_output_taken = r_output_taken;
  assign bus.busy            = r_busy;
  assign bus.timeout_err     = r_timeout_err;
  assign bus.op_count        = r_op_count;
endmodule

// File: tb/tb_ln_forward_scheduler.sv
// Bench for ln_forward_scheduler: a behavioural LN unit plus per-feature scenario tasks.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ln_forward_scheduler;
  localparam int unsigned NReq       = 4;
  localparam int unsigned TimeoutCyc = 16;
  localparam int unsigned CntW       = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ln_forward_scheduler_if #(.N_REQ(NReq), .CNT_W(CntW)) bus ();

  ln_forward_scheduler #(
    .N_REQ  (NReq),
    .TIMEOUT(TimeoutCyc),
    .CNT_W  (CntW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vec  = 0;
  int errs = 0;

  // Behavioural LN unit: starts on input_ready while idle, raises done lat cycles later,
  // holds the result until output_taken. force_en overrides its visible state and freezes it.
  logic [1:0] u_state;
  logic       u_done;
  int         u_cnt;
  int         lat = 3;
  logic       hang = 1'b0;
  logic       force_en = 1'b0;
  logic [1:0] force_val = 2'b00;

  always @(posedge clk) begin
    if (reset) begin
      u_state <= 2'b00;
      u_done  <= 1'b0;
      u_cnt   <= 0;
    end else if (!force_en) begin
      u_done <= 1'b0;
      case (u_state)
        2'b00: if (bus.ln_input_ready) begin
          u_state <= 2'b01;
          u_cnt   <= lat - 1;
        end
        2'b01: if (!hang) begin
          if (u_cnt <= 1) begin
            u_done  <= 1'b1;
            u_state <= 2'b10;
          end else begin
            u_cnt <= u_cnt - 1;
          end
        end
        2'b10: if (bus.ln_output_taken) u_state <= 2'b00;
        default: u_state <= 2'b00;
      endcase
    end
  end

  assign bus.ln_state = force_en ? force_val : u_state;
  assign bus.ln_done  = u_done;

  function automatic logic probe(input int which);
    case (which)
      0:       return bus.ln_input_ready;
      1:       return |bus.resp_valid;
      2:       return bus.ln_output_taken;
      3:       return !bus.busy;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (probe(which)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.req         = '0;
    bus.resp_ready  = '0;
    force_en        = 1'b0;
    hang            = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Round-robin rule: first set request at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [NReq-1:0] r, input int p);
    for (int i = 0; i < NReq; i++) begin
      if (r[(p + i) % NReq]) return (p + i) % NReq;
    end
    return -1;
  endfunction

  task automatic test_reset();
    do_reset();
    vec++; if (bus.gnt !== 4'b0000) begin errs++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    vec++; if (bus.gnt_idx !== 2'd0) begin errs++; $display("FAIL reset_gnt_idx: got %0d want 0", bus.gnt_idx); end
    vec++; if (bus.resp_valid !== 4'b0000) begin errs++; $display("FAIL reset_resp_valid: got %b want 0000", bus.resp_valid); end
    vec++; if ({bus.ln_input_ready, bus.ln_output_taken} !== 2'b00) begin errs++; $display("FAIL reset_handshake: got %b want 00", {bus.ln_input_ready, bus.ln_output_taken}); end
    vec++; if ({bus.busy, bus.timeout_err} !== 2'b00) begin errs++; $display("FAIL reset_status: got %b want 00", {bus.busy, bus.timeout_err}); end
    vec++; if (bus.op_count !== 4'd0) begin errs++; $display("FAIL reset_op_count: got %0d want 0", bus.op_count); end
  endtask

  task automatic test_single();
    bit ok;
    int n;
    lat     = 10;
    bus.req = 4'b0001;
    wait_for(0, ok);
    vec++; if (!ok) begin errs++; $display("FAIL single_issue: got timeout want input_ready"); end
    vec++; if (bus.gnt !== 4'b0001 || bus.gnt_idx !== 2'd0) begin errs++; $display("FAIL single_gnt: got %b/%0d want 0001/0", bus.gnt, bus.gnt_idx); end
    bus.req = 4'b0000;
    @(negedge clk);
    vec++; if (bus.ln_input_ready !== 1'b0 || bus.gnt !== 4'b0001) begin errs++; $display("FAIL single_ir_pulse: got ir=%b gnt=%b want 0/0001", bus.ln_input_ready, bus.gnt); end
    n = 1;
    while (!(|bus.resp_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    vec++; if (n != 11) begin errs++; $display("FAIL single_latency: got %0d want 11 cycles", n); end
    vec++; if (bus.resp_valid !== 4'b0001) begin errs++; $display("FAIL single_resp_valid: got %b want 0001", bus.resp_valid); end
    bus.resp_ready = 4'b0001;
    @(negedge clk);
    vec++; if (bus.ln_output_taken !== 1'b1 || bus.resp_valid !== 4'b0000) begin errs++; $display("FAIL single_taken: got ot=%b rv=%b want 1/0000", bus.ln_output_taken, bus.resp_valid); end
    bus.resp_ready = 4'b0000;
    @(negedge clk);
    vec++; if (bus.ln_output_taken !== 1'b0 || bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin errs++; $display("FAIL single_idle: got ot=%b busy=%b gnt=%b want 0/0/0000", bus.ln_output_taken, bus.busy, bus.gnt); end
    vec++; if (bus.op_count !== 4'd1) begin errs++; $display("FAIL single_op_count: got %0d want 1", bus.op_count); end
  endtask

  task automatic test_fairness();
    bit ok;
    do_reset();
    lat            = 3;
    bus.resp_ready = 4'b1111;
    bus.req        = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_for(0, ok);
      vec++; if (!ok) begin errs++; $display("FAIL fair_issue%0d: got timeout want input_ready", k); end
      vec++; if (bus.gnt_idx !== 2'(k % 4) || bus.gnt !== (4'b0001 << (k % 4))) begin errs++; $display("FAIL fair_order%0d: got %0d/%b want %0d", k, bus.gnt_idx, bus.gnt, k % 4); end
      if (k == 7) bus.req = 4'b0000;
    end
    wait_for(3, ok);
    vec++; if (!ok || bus.op_count !== 4'd8) begin errs++; $display("FAIL fair_op_count: got %0d want 8", bus.op_count); end
    bus.resp_ready = 4'b0000;
  endtask

  task automatic test_not_idle();
    bit ok;
    lat       = 4;
    force_en  = 1'b1;
    force_val = 2'b10;
    bus.req   = 4'b0010;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      vec++; if (bus.ln_input_ready !== 1'b1 || bus.gnt !== 4'b0010) begin errs++; $display("FAIL notidle_hold%0d: got ir=%b gnt=%b want 1/0010", n, bus.ln_input_ready, bus.gnt); end
      if (n == 5) force_en = 1'b0;
    end
    bus.req = 4'b0000;
    @(negedge clk);
    vec++; if (bus.ln_input_ready !== 1'b0 || bus.gnt !== 4'b0010 || bus.busy !== 1'b1) begin errs++; $display("FAIL notidle_wait: got ir=%b gnt=%b busy=%b want 0/0010/1", bus.ln_input_ready, bus.gnt, bus.busy); end
    wait_for(1, ok);
    vec++; if (!ok || bus.resp_valid !== 4'b0010) begin errs++; $display("FAIL notidle_resp: got %b want 0010", bus.resp_valid); end
    bus.resp_ready = 4'b0010;
    wait_for(2, ok);
    bus.resp_ready = 4'b0000;
    wait_for(3, ok);
    vec++; if (!ok || bus.op_count !== 4'd9) begin errs++; $display("FAIL notidle_op_count: got %0d want 9", bus.op_count); end
  endtask

  task automatic test_backpressure();
    bit ok;
    lat     = 3;
    bus.req = 4'b1000;
    wait_for(0, ok);
    vec++; if (!ok || bus.gnt !== 4'b1000) begin errs++; $display("FAIL bp_gnt: got %b want 1000", bus.gnt); end
    bus.req = 4'b0000;
    wait_for(1, ok);
    vec++; if (!ok) begin errs++; $display("FAIL bp_resp: got timeout want resp_valid"); end
    for (int i = 0; i < 20; i++) begin
      vec++; if ({bus.resp_valid, bus.ln_output_taken, bus.gnt} !== {4'b1000, 1'b0, 4'b1000}) begin errs++; $display("FAIL bp_hold%0d: got rv=%b ot=%b gnt=%b want 1000/0/1000", i, bus.resp_valid, bus.ln_output_taken, bus.gnt); end
      bus.resp_ready = (i == 19) ? 4'b1000 : 4'b0111;
      @(negedge clk);
    end
    vec++; if (bus.ln_output_taken !== 1'b1 || bus.resp_valid !== 4'b0000) begin errs++; $display("FAIL bp_taken: got ot=%b rv=%b want 1/0000", bus.ln_output_taken, bus.resp_valid); end
    bus.resp_ready = 4'b0000;
    @(negedge clk);
    vec++; if (bus.ln_output_taken !== 1'b0 || bus.busy !== 1'b0) begin errs++; $display("FAIL bp_one_taken: got ot=%b busy=%b want 0/0", bus.ln_output_taken, bus.busy); end
  endtask

  task automatic test_random();
    bit ok;
    int mptr = 0;
    int mcount = 0;
    int exp_idx;
    logic [NReq-1:0] req_now;
    do_reset();
    req_now = 4'($urandom_range(1, 15));
    bus.req = req_now;
    for (int op = 0; op < 20; op++) begin
      lat     = $urandom_range(2, 14);
      exp_idx = rr_pick(req_now, mptr);
      wait_for(0, ok);
      vec++; if (!ok || bus.gnt !== (4'b0001 << exp_idx)) begin errs++; $display("FAIL rand_gnt%0d: got %b want idx %0d (req %b)", op, bus.gnt, exp_idx, req_now); end
      bus.req = 4'($urandom);
      wait_for(1, ok);
      vec++; if (!ok || bus.resp_valid !== (4'b0001 << exp_idx)) begin errs++; $display("FAIL rand_resp%0d: got %b want idx %0d", op, bus.resp_valid, exp_idx); end
      repeat ($urandom_range(0, 4)) begin
        bus.resp_ready = 4'($urandom) & ~(4'b0001 << exp_idx);
        @(negedge clk);
      end
      bus.resp_ready = (4'b0001 << exp_idx) | 4'($urandom);
      wait_for(2, ok);
      vec++; if (!ok) begin errs++; $display("FAIL rand_taken%0d: got timeout want output_taken", op); end
      mcount         = (mcount + 1) % 16;
      mptr           = (exp_idx + 1) % NReq;
      bus.resp_ready = 4'b0000;
      req_now        = 4'($urandom_range(1, 15));
      bus.req        = req_now;
      @(negedge clk);
      vec++; if (bus.busy !== 1'b0 || bus.op_count !== 4'(mcount)) begin errs++; $display("FAIL rand_count%0d: got busy=%b cnt=%0d want 0/%0d", op, bus.busy, bus.op_count, mcount); end
    end
    bus.req = 4'b0000;
    wait_for(3, ok);
    bus.resp_ready = 4'b1111;
    wait_for(3, ok);
    bus.resp_ready = 4'b0000;
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    do_reset();
    lat     = 3;
    bus.req = 4'b0010;
    wait_for(0, ok);
    bus.req        = 4'b0000;
    bus.resp_ready = 4'b0010;
    wait_for(3, ok);
    bus.resp_ready = 4'b0000;
    lat     = 10;
    bus.req = 4'b0100;
    wait_for(0, ok);
    vec++; if (!ok || bus.gnt !== 4'b0100) begin errs++; $display("FAIL rstwait_gnt: got %b want 0100", bus.gnt); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vec++; if ({bus.gnt, bus.resp_valid, bus.ln_input_ready, bus.ln_output_taken, bus.busy, bus.timeout_err} !== 12'd0) begin errs++; $display("FAIL rstwait_outputs: got gnt=%b rv=%b ir=%b ot=%b busy=%b te=%b want all 0", bus.gnt, bus.resp_valid, bus.ln_input_ready, bus.ln_output_taken, bus.busy, bus.timeout_err); end
    vec++; if (bus.op_count !== 4'd0 || bus.gnt_idx !== 2'd0) begin errs++; $display("FAIL rstwait_count: got cnt=%0d idx=%0d want 0/0", bus.op_count, bus.gnt_idx); end
    reset   = 1'b0;
    bus.req = 4'b0101;
    wait_for(0, ok);
    vec++; if (!ok || bus.gnt !== 4'b0001) begin errs++; $display("FAIL rstwait_ptr: got %b want 0001", bus.gnt); end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    hang    = 1'b1;
    bus.req = 4'b0001;
    wait_for(0, ok);
    vec++; if (!ok) begin errs++; $display("FAIL to_issue: got timeout want input_ready"); end
    bus.req = 4'b0000;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      vec++; if ({bus.timeout_err, bus.gnt, bus.busy} !== {1'b0, 4'b0001, 1'b1}) begin errs++; $display("FAIL to_wait%0d: got te=%b gnt=%b busy=%b want 0/0001/1", i, bus.timeout_err, bus.gnt, bus.busy); end
      @(negedge clk);
    end
    vec++; if ({bus.timeout_err, bus.gnt, bus.busy, bus.ln_input_ready} !== {1'b1, 4'b0000, 1'b1, 1'b0}) begin errs++; $display("FAIL to_err: got te=%b gnt=%b busy=%b ir=%b want 1/0000/1/0", bus.timeout_err, bus.gnt, bus.busy, bus.ln_input_ready); end
    bus.req = 4'b0010;
    repeat (5) @(negedge clk);
    vec++; if ({bus.timeout_err, bus.gnt, bus.ln_input_ready, bus.resp_valid} !== {1'b1, 4'b0000, 1'b0, 4'b0000}) begin errs++; $display("FAIL to_sticky: got te=%b gnt=%b ir=%b rv=%b want 1/0000/0/0000", bus.timeout_err, bus.gnt, bus.ln_input_ready, bus.resp_valid); end
    do_reset();
    vec++; if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin errs++; $display("FAIL to_cleared: got te=%b busy=%b want 0/0", bus.timeout_err, bus.busy); end
  endtask

  initial begin
    bus.req        = '0;
    bus.resp_ready = '0;
    test_reset();
    test_single();
    test_fairness();
    test_not_idle();
    test_backpressure();
    test_random();
    test_reset_mid_wait();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
